// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift window.
// Ports: clk, rst (sync, active-high), pixel_in/pixel_in_valid in,
// img_vector/img_vector_valid/frame_done out; WINGEN_FRAME_SYNC_EN adds sof.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic        clk,
  input  logic        rst,
`ifdef WINGEN_FRAME_SYNC_EN
  input  logic        sof,
`endif
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
  output logic [71:0] img_vector,
  output logic        img_vector_valid,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic {
    FILL,
    STREAM
  } state_t;

  state_t          state;
  state_t          st_eff;
  logic [CW-1:0]   col;
  logic [CW-1:0]   col_eff;
  logic [RW-1:0]   row;
  logic [RW-1:0]   row_eff;

  logic [7:0]      lb_top [IMG_WIDTH];
  logic [7:0]      lb_mid [IMG_WIDTH];
  logic [7:0]      win     [9];
  logic [7:0]      win_nxt [9];
  logic [71:0]     vec_nxt;

  logic            line_end;
  logic            frame_end;
  logic            to_stream;
  logic            emit;

  // Position the current pixel is treated as (sof forces 0,0 / FILL).
  always_comb begin
    col_eff = col;
    row_eff = row;
    st_eff  = state;
`ifdef WINGEN_FRAME_SYNC_EN
    if (sof) begin
      col_eff = '0;
      row_eff = '0;
      st_eff  = FILL;
    end
`endif
  end

  assign line_end  = (col_eff == CW'(IMG_WIDTH - 1));
  assign frame_end = line_end && (row_eff == RW'(IMG_HEIGHT - 1));
  assign to_stream = (st_eff == FILL) && line_end
                     && (row_eff == RW'(1));
  // Cols 0-1 would mix in the previous line's tail, so suppress them.
  assign emit      = (st_eff == STREAM) && (col_eff >= CW'(2));

  // Shift window left; new right column is {top, mid, incoming}.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[3*r]     = win[3*r+1];
      win_nxt[3*r + 1] = win[3*r+2];
    end
    win_nxt[2] = lb_top[col_eff];
    win_nxt[5] = lb_mid[col_eff];
    win_nxt[8] = pixel_in;
    vec_nxt = '0;
    for (int k = 0; k < 9; k++) begin
      vec_nxt[8*k +: 8] = win_nxt[k];
    end
  end

  // Storage is never cleared; row/col gating makes stale data harmless.
  always_ff @(posedge clk) begin
    if (pixel_in_valid) begin
      lb_top[col_eff] <= lb_mid[col_eff];
      lb_mid[col_eff] <= pixel_in;
      win             <= win_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FILL;
      col              <= '0;
      row              <= '0;
      img_vector       <= '0;
      img_vector_valid <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      img_vector_valid <= 1'b0;
      frame_done       <= 1'b0;
      if (pixel_in_valid) begin
        if (emit) begin
          img_vector       <= vec_nxt;
          img_vector_valid <= 1'b1;
          frame_done       <= frame_end;
        end
        col <= line_end ? '0 : col_eff + 1'b1;
        if (line_end) begin
          row <= frame_end ? '0 : row_eff + 1'b1;
        end else begin
          row <= row_eff;
        end
        unique case (1'b1)
          to_stream: state <= STREAM;
          frame_end: state <= FILL;
          default:   state <= st_eff;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: 4x4 and 28x28 instances,
// immediate-assertion checks on every cycle that a pixel or gap is sampled.
module tb_window_gen_3x3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  pix4;
  logic [7:0]  pix28;
  logic        vld4;
  logic        vld28;
  logic [71:0] vec4;
  logic [71:0] vec28;
  logic        ov4;
  logic        ov28;
  logic        fd4;
  logic        fd28;
`ifdef WINGEN_FRAME_SYNC_EN
  logic        sof4;
  logic        sof28;
`endif

  int          total = 0;
  int          bad   = 0;
  int          nwin4;
  int          nfd4;
  int          nwin28;
  int          nfd28;
  logic [71:0] hold4;
  logic [71:0] hold28;
  logic [71:0] first4;
  logic [71:0] spot28;

  window_gen_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (
    .clk              (clk),
    .rst              (rst),
`ifdef WINGEN_FRAME_SYNC_EN
    .sof              (sof4),
`endif
    .pixel_in         (pix4),
    .pixel_in_valid   (vld4),
    .img_vector       (vec4),
    .img_vector_valid (ov4),
    .frame_done       (fd4)
  );

  window_gen_3x3 #(.IMG_WIDTH(28), .IMG_HEIGHT(28)) u28 (
    .clk              (clk),
    .rst              (rst),
`ifdef WINGEN_FRAME_SYNC_EN
    .sof              (sof28),
`endif
    .pixel_in         (pix28),
    .pixel_in_valid   (vld28),
    .img_vector       (vec28),
    .img_vector_valid (ov28),
    .frame_done       (fd28)
  );

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit big, input bit ev,
                        input logic [71:0] evec, input bit efd);
    logic        v;
    logic        f;
    logic [71:0] x;
    v = big ? ov28 : ov4;
    f = big ? fd28 : fd4;
    x = big ? vec28 : vec4;
    chk("valid", {71'd0, v}, {71'd0, ev});
    chk("frame_done", {71'd0, f}, {71'd0, efd});
    if (ev) begin
      chk("window", x, evec);
      if (big) hold28 = evec;
      else hold4 = evec;
    end else begin
      chk("hold", x, big ? hold28 : hold4);
    end
    if (v === 1'b1) begin
      if (big) nwin28++;
      else nwin4++;
    end
    if (f === 1'b1) begin
      if (big) nfd28++;
      else nfd4++;
    end
  endtask

  task automatic step(input bit big, input logic [7:0] p, input bit s,
                      input bit ev, input logic [71:0] evec,
                      input bit efd);
    if (big) begin
      pix28 = p;
      vld28 = 1'b1;
    end else begin
      pix4 = p;
      vld4 = 1'b1;
    end
`ifdef WINGEN_FRAME_SYNC_EN
    if (big) sof28 = s;
    else sof4 = s;
`else
    if (s) $display("note: sof ignored in this build");
`endif
    @(posedge clk);
    #1;
    vld4  = 1'b0;
    vld28 = 1'b0;
`ifdef WINGEN_FRAME_SYNC_EN
    sof4  = 1'b0;
    sof28 = 1'b0;
`endif
    sample(big, ev, evec, efd);
  endtask

  task automatic idle(input bit big);
    @(posedge clk);
    #1;
    sample(big, 1'b0, '0, 1'b0);
  endtask

  // Window ending at (r,c) of a 4x4 frame whose pixels are base+1..base+16.
  function automatic logic [71:0] win4(input int base, input int r,
                                       input int c);
    logic [71:0] v;
    v = '0;
    for (int ro = 0; ro < 3; ro++)
      for (int co = 0; co < 3; co++)
        v[8*(3*ro+co) +: 8] = 8'(base + (r-2+ro)*4 + (c-2+co) + 1);
    return v;
  endfunction

  // Window ending at (r,c) of the 28x28 ramp (value = index mod 256).
  function automatic logic [71:0] win28(input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int ro = 0; ro < 3; ro++)
      for (int co = 0; co < 3; co++)
        v[8*(3*ro+co) +: 8] = 8'(((r-2+ro)*28 + (c-2+co)) % 256);
    return v;
  endfunction

  task automatic frame4(input int base, input int maxgap,
                        input bit sof_first);
    int  r;
    int  c;
    bit  ev;
    for (int i = 0; i < 16; i++) begin
      r  = i / 4;
      c  = i % 4;
      ev = (r >= 2) && (c >= 2);
      step(1'b0, 8'(base + i + 1), sof_first && (i == 0), ev,
           ev ? win4(base, r, c) : '0, i == 15);
      if (r == 2 && c == 2) first4 = vec4;
      repeat ($urandom_range(maxgap, 0)) idle(1'b0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    pix4   = '0;
    pix28  = '0;
    vld4   = 1'b0;
    vld28  = 1'b0;
`ifdef WINGEN_FRAME_SYNC_EN
    sof4   = 1'b0;
    sof28  = 1'b0;
`endif
    hold4  = '0;
    hold28 = '0;
    first4 = '0;
    spot28 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", vec4, '0);
    chk("rst_valid", {71'd0, ov4}, '0);
    chk("rst_fd", {71'd0, fd4}, '0);
    chk("rst_valid28", {71'd0, ov28}, '0);
    rst = 1'b0;

    // Back-to-back single frame.
    nwin4 = 0;
    nfd4  = 0;
    frame4(0, 0, 1'b0);
    chk("t1_count", nwin4, 4);
    chk("t1_fd", nfd4, 1);
    chk("t1_first", first4, 72'h0B0A09070605030201);

    // Same frame with random 0-3 cycle gaps.
    nwin4 = 0;
    nfd4  = 0;
    frame4(0, 3, 1'b0);
    chk("t2_count", nwin4, 4);
    chk("t2_fd", nfd4, 1);
    chk("t2_first", first4, 72'h0B0A09070605030201);

    // Two frames back-to-back.
    nwin4 = 0;
    nfd4  = 0;
    frame4(0, 0, 1'b0);
    frame4(100, 0, 1'b0);
    chk("t3_count", nwin4, 8);
    chk("t3_fd", nfd4, 2);
    chk("t3_first2", first4, 72'h6F6E6D6B6A69676665);

    // Reset after pixel 10, then a fresh frame.
    for (int i = 0; i < 10; i++)
      step(1'b0, 8'(i + 1), 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t4_rst_valid", {71'd0, ov4}, '0);
    chk("t4_rst_fd", {71'd0, fd4}, '0);
    chk("t4_rst_vec", vec4, '0);
    hold4  = '0;
    hold28 = '0;
    nwin4  = 0;
    nfd4   = 0;
    frame4(0, 0, 1'b0);
    chk("t4_count", nwin4, 4);
    chk("t4_fd", nfd4, 1);
    chk("t4_first", first4, 72'h0B0A09070605030201);

    // Full 28x28 ramp.
    nwin28 = 0;
    nfd28  = 0;
    for (int i = 0; i < 784; i++) begin
      int  r;
      int  c;
      bit  ev;
      r  = i / 28;
      c  = i % 28;
      ev = (r >= 2) && (c >= 2);
      step(1'b1, 8'(i % 256), 1'b0, ev,
           ev ? win28(r, c) : '0, i == 783);
      if (i == 783) spot28 = vec28;
    end
    chk("t5_count", nwin28, 676);
    chk("t5_fd", nfd28, 1);
    chk("t5_spot", spot28, 72'h0F0E0DF3F2F1D7D6D5);

`ifdef WINGEN_FRAME_SYNC_EN
    // Partial frame abandoned by sof.
    nwin4 = 0;
    nfd4  = 0;
    for (int i = 0; i < 6; i++)
      step(1'b0, 8'(i + 1), 1'b0, 1'b0, '0, 1'b0);
    frame4(0, 0, 1'b1);
    chk("t6_count", nwin4, 4);
    chk("t6_fd", nfd4, 1);
    chk("t6_first", first4, 72'h0B0A09070605030201);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
